mem_access_stage: RTL and testbench

Memory stage directly downstream of the execute stage. Registers the execute results (ALU result, store data, destination register), performs word loads/stores on an internal data memory with a configurable multi-cycle latency, and presents a registered, single-cycle-valid result bundle to the MEM/WB side. It raises `stall` so upstream stages hold their inputs while a memory access is in flight.

---
 rtl/mem_access_stage.sv | 97 +++++++++
 tb/tb_mem_access_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: registers execute results and performs multi-cycle word loads/stores on an internal data memory.
module mem_access_stage #(
  parameter int MEM_DEPTH   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        inValid,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  input  logic [4:0]  rdOrRt,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        regWrite,
  output logic        stall,
  output logic        outValid,
  output logic [31:0] readData,
  output logic [31:0] aluResultOut,
  output logic [4:0]  rdOut,
  output logic        memToRegOut,
  output logic        regWriteOut,
  output logic        memError
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_data;
  logic [4:0]  r_rd;
  logic        r_rdop, r_wrop, r_m2r, r_rw;
  logic        w_mem_op, w_bad, w_accept, w_pass, w_done;
  logic [AW-1:0] w_idx;
  logic [31:0] r_mem [MEM_DEPTH] = '{default: '0};
  always_comb begin
    w_mem_op = inValid & (memRead ^ memWrite) & (aluResult[1:0] == 2'b00);
    w_bad    = (memRead | memWrite) & ~w_mem_op;
    w_accept = (r_state == IDLE) & w_mem_op;
    w_pass   = (r_state == IDLE) & inValid & ~w_mem_op;
    w_done   = (r_state == BUSY) & (r_cnt == 4'd0);
    w_idx    = r_addr[AW+1:2];
    w_next   = w_accept ? BUSY : w_done ? IDLE : r_state;
  end
  assign stall = (r_state == BUSY);
  // Memory is deliberately outside the reset domain; an aborted BUSY never reaches w_done.
  always_ff @(posedge CLK)
    if (w_done && r_wrop) r_mem[w_idx] <= r_data;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_rd         <= '0;
      r_rdop       <= 1'b0;
      r_wrop       <= 1'b0;
      r_m2r        <= 1'b0;
      r_rw         <= 1'b0;
      outValid     <= 1'b0;
      memError     <= 1'b0;
      readData     <= '0;
      aluResultOut <= '0;
      rdOut        <= '0;
      memToRegOut  <= 1'b0;
      regWriteOut  <= 1'b0;
    end else begin
      r_state  <= w_next;
      outValid <= w_pass | w_done;
      memError <= w_pass & w_bad;
      if (w_accept) begin
        r_cnt  <= 4'(MEM_LATENCY - 1);
        r_addr <= aluResult;
        r_data <= storeData;
        r_rd   <= rdOrRt;
        r_rdop <= memRead;
        r_wrop <= memWrite;
        r_m2r  <= memToReg;
        r_rw   <= regWrite;
      end else if (stall && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_pass) begin
        readData     <= '0;
        aluResultOut <= aluResult;
        rdOut        <= rdOrRt;
        memToRegOut  <= memToReg;
        regWriteOut  <= regWrite & ~w_bad;
      end else if (w_done) begin
        readData     <= r_rdop ? r_mem[w_idx] : '0;
        aluResultOut <= r_addr;
        rdOut        <= r_rd;
        memToRegOut  <= r_m2r;
        regWriteOut  <= r_rw;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of pass-through, load/store latency, wrap, errors and reset abort.
module tb_mem_access_stage;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        inValid = 1'b0, memRead = 1'b0, memWrite = 1'b0, memToReg = 1'b0, regWrite = 1'b0;
  logic [31:0] aluResult = '0, storeData = '0;
  logic [4:0]  rdOrRt = '0;
  logic        stall, outValid, memToRegOut, regWriteOut, memError;
  logic [31:0] readData, aluResultOut;
  logic [4:0]  rdOut;
  int n_cmp = 0, n_bad = 0;
  mem_access_stage dut (
    .CLK(CLK), .RST_N(RST_N), .inValid(inValid), .aluResult(aluResult), .storeData(storeData),
    .rdOrRt(rdOrRt), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
    .stall(stall), .outValid(outValid), .readData(readData), .aluResultOut(aluResultOut), .rdOut(rdOut),
    .memToRegOut(memToRegOut), .regWriteOut(regWriteOut), .memError(memError)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic m2r, input logic rw);
    inValid = v; aluResult = a; storeData = d; rdOrRt = rd;
    memRead = mr; memWrite = mw; memToReg = m2r; regWrite = rw;
  endtask
  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_valid", outValid, 0);
    chk("rst_rdata", readData, 0);
    chk("rst_alu", aluResultOut, 0);
    chk("rst_rd", rdOut, 0);
    chk("rst_err", memError, 0);
    chk("rst_rw", regWriteOut, 0);
    @(negedge CLK); RST_N = 1'b1;
    tick();
    drive(1'b1, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("pt_valid", outValid, 1);
    chk("pt_alu", aluResultOut, 32'h10);
    chk("pt_rd", rdOut, 5);
    chk("pt_rdata", readData, 0);
    chk("pt_rw", regWriteOut, 1);
    chk("pt_stall", stall, 0);
    idle();
    tick();
    chk("pt_pulse", outValid, 0);
    chk("pt_hold_alu", aluResultOut, 32'h10);
    drive(1'b1, 32'h8, 32'hDEADBEEF, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("st_stall1", stall, 1);
    chk("st_valid1", outValid, 0);
    idle();
    tick();
    chk("st_stall2", stall, 1);
    chk("st_valid2", outValid, 0);
    tick();
    chk("st_stall3", stall, 0);
    chk("st_valid3", outValid, 1);
    chk("st_alu", aluResultOut, 32'h8);
    chk("st_rdata", readData, 0);
    drive(1'b1, 32'h8, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("ld_stall1", stall, 1);
    idle();
    tick();
    chk("ld_valid_early", outValid, 0);
    tick();
    chk("ld_valid", outValid, 1);
    chk("ld_rdata", readData, 32'hDEADBEEF);
    chk("ld_rw", regWriteOut, 1);
    chk("ld_m2r", memToRegOut, 1);
    chk("ld_rd", rdOut, 7);
    chk("ld_err", memError, 0);
    tick();
    chk("ld_pulse", outValid, 0);
    drive(1'b1, 32'h404, 32'h12345678, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); idle(); tick(); tick();
    chk("wr_st_valid", outValid, 1);
    drive(1'b1, 32'h4, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'hABC, 32'h99, 5'd31, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("wr_stall", stall, 1);
    tick();
    idle();
    chk("wr_rdata", readData, 32'h12345678);
    chk("wr_alu_orig", aluResultOut, 32'h4);
    chk("wr_rd_orig", rdOut, 9);
    tick();
    chk("wr_no_reaccept", stall, 0);
    drive(1'b1, 32'h6, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("mis_valid", outValid, 1);
    chk("mis_err", memError, 1);
    chk("mis_rw", regWriteOut, 0);
    chk("mis_rdata", readData, 0);
    chk("mis_stall", stall, 0);
    chk("mis_alu", aluResultOut, 32'h6);
    drive(1'b1, 32'h8, 32'h55, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("ill_valid", outValid, 1);
    chk("ill_err", memError, 1);
    chk("ill_rw", regWriteOut, 0);
    chk("ill_stall", stall, 0);
    idle();
    tick();
    chk("ill_pulse", outValid, 0);
    chk("ill_err_clr", memError, 0);
    drive(1'b1, 32'h8, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); idle(); tick(); tick();
    chk("ill_nowrite", readData, 32'hDEADBEEF);
    drive(1'b1, 32'h20, 32'hFFFFFFFF, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("ab_stall_pre", stall, 1);
    RST_N = 1'b0;
    #1;
    chk("ab_stall", stall, 0);
    chk("ab_valid", outValid, 0);
    chk("ab_alu", aluResultOut, 0);
    chk("ab_rdata", readData, 0);
    tick();
    @(negedge CLK); RST_N = 1'b1;
    tick();
    chk("ab_no_valid", outValid, 0);
    drive(1'b1, 32'h20, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(); idle(); tick(); tick();
    chk("ab_ld_valid", outValid, 1);
    chk("ab_ld_rdata", readData, 0);
    chk("ab_ld_alu", aluResultOut, 32'h20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
